// File: rtl/conv3x3_stream_if.sv
// FIFO-style stream handshakes around the 3x3 filter: upstream show-ahead pop
// port and downstream push port, bundled as one interface.
interface conv3x3_stream_if #(
  parameter int unsigned PIXEL_WIDTH = 8
);
  logic                   in_rd_en;
  logic                   in_empty;
  logic [PIXEL_WIDTH-1:0] in_dout;
  logic                   out_wr_en;
  logic                   out_full;
  logic [PIXEL_WIDTH-1:0] out_din;

  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 neighbourhood filter (passthrough / Sobel / Gaussian / Sobel
// threshold), one output pixel per input pixel, trailing row flushed as zeros.
module conv3x3_stream #(
  parameter int unsigned IMG_WIDTH   = 720,
  parameter int unsigned IMG_HEIGHT  = 540,
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_mode,
  input  logic [PIXEL_WIDTH-1:0] i_thresh,
  conv3x3_stream_if.master       fifo,
  output logic                   o_frame_done,
  output logic                   o_busy
);
  localparam int unsigned PW = PIXEL_WIDTH;
  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam int unsigned FW = $clog2(IMG_WIDTH + 2);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;
  typedef logic [PW-1:0] pix_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [FW-1:0] r_fcnt;
  logic [1:0]    r_mode;
  pix_t          r_thresh;
  logic          r_busy;
  logic          r_out_valid;
  pix_t          r_out_data;
  pix_t          r_win [3][3];
  pix_t          r_lb0 [IMG_WIDTH];
  pix_t          r_lb1 [IMG_WIDTH];

  pix_t          w_win [3][3];
  logic          w_free, w_accept, w_pop, w_border, w_last_in, w_flush_end;
  logic [PW+1:0] w_gxp, w_gxn, w_gyp, w_gyn;
  logic signed [PW+2:0] w_gx, w_gy;
  logic [PW+2:0] w_ax, w_ay;
  logic [PW+3:0] w_mag, w_gsum;
  pix_t          w_filt;

  assign w_free      = !r_out_valid || !fifo.out_full;
  assign w_accept    = r_out_valid && !fifo.out_full;
  assign w_pop       = i_rst_n && (r_state != S_FLUSH) && !fifo.in_empty && w_free;
  assign w_last_in   = (r_col == CW'(IMG_WIDTH - 1)) && (r_row == RW'(IMG_HEIGHT - 1));
  assign w_flush_end = (r_fcnt == FW'(IMG_WIDTH + 1));

  // Centre sits one row up and one column left of the pixel being consumed;
  // centre row IMG_HEIGHT-1 is only ever reached during FLUSH.
  assign w_border = (r_col < CW'(2)) || (r_row == RW'(1));

  assign fifo.in_rd_en  = w_pop;
  assign fifo.out_wr_en = w_accept;
  assign fifo.out_din   = r_out_data;
  assign o_frame_done   = (r_state == S_FLUSH) && w_flush_end && w_accept;
  assign o_busy         = r_busy;

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      w_win[r][0] = r_win[r][1];
      w_win[r][1] = r_win[r][2];
    end
    w_win[0][2] = r_lb1[r_col];
    w_win[1][2] = r_lb0[r_col];
    w_win[2][2] = fifo.in_dout;
  end

  always_comb begin
    w_gxp = (PW+2)'(w_win[0][2]) + ((PW+2)'(w_win[1][2]) << 1) + (PW+2)'(w_win[2][2]);
    w_gxn = (PW+2)'(w_win[0][0]) + ((PW+2)'(w_win[1][0]) << 1) + (PW+2)'(w_win[2][0]);
    w_gyp = (PW+2)'(w_win[2][0]) + ((PW+2)'(w_win[2][1]) << 1) + (PW+2)'(w_win[2][2]);
    w_gyn = (PW+2)'(w_win[0][0]) + ((PW+2)'(w_win[0][1]) << 1) + (PW+2)'(w_win[0][2]);
    w_gx  = $signed({1'b0, w_gxp}) - $signed({1'b0, w_gxn});
    w_gy  = $signed({1'b0, w_gyp}) - $signed({1'b0, w_gyn});
    w_ax  = w_gx[PW+2] ? unsigned'(-w_gx) : unsigned'(w_gx);
    w_ay  = w_gy[PW+2] ? unsigned'(-w_gy) : unsigned'(w_gy);
    w_mag = {1'b0, w_ax} + {1'b0, w_ay};
    w_gsum = (PW+4)'(w_win[0][0]) + (PW+4)'(w_win[0][2]) + (PW+4)'(w_win[2][0])
           + (PW+4)'(w_win[2][2])
           + (((PW+4)'(w_win[0][1]) + (PW+4)'(w_win[1][0]) + (PW+4)'(w_win[1][2])
              + (PW+4)'(w_win[2][1])) << 1)
           + ((PW+4)'(w_win[1][1]) << 2) + (PW+4)'(8);
    unique case (r_mode)
      2'd0:    w_filt = w_win[1][1];
      2'd1:    w_filt = (w_mag > (PW+4)'({PW{1'b1}})) ? '1 : w_mag[PW-1:0];
      2'd2:    w_filt = w_gsum[PW+3:4];
      default: w_filt = (w_mag >= (PW+4)'(r_thresh)) ? '1 : '0;
    endcase
    if (w_border) w_filt = '0;
  end

  always_ff @(posedge i_clk) begin
    if (w_pop) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= fifo.in_dout;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_FILL;
      r_col       <= '0;
      r_row       <= '0;
      r_fcnt      <= '0;
      r_mode      <= '0;
      r_thresh    <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else begin
      if (w_pop) begin
        r_win <= w_win;
        if (r_col == CW'(IMG_WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_HEIGHT - 1)) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      unique case (r_state)
        S_FILL: begin
          if (w_accept) r_out_valid <= 1'b0;
          if (w_pop && r_col == '0 && r_row == '0) begin
            r_mode   <= i_mode;
            r_thresh <= i_thresh;
            r_busy   <= 1'b1;
          end
          if (w_pop && r_col == '0 && r_row == RW'(1)) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_filt;
            if (w_last_in) r_state <= S_FLUSH;
          end else if (w_accept) begin
            r_out_valid <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (!w_flush_end) begin
            if (w_free) begin
              r_out_valid <= 1'b1;
              r_out_data  <= '0;
              r_fcnt      <= r_fcnt + FW'(1);
            end
          end else if (w_accept) begin
            r_out_valid <= 1'b0;
            r_fcnt      <= '0;
            r_busy      <= 1'b0;
            r_state     <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on an 8x6 image: vector table of whole
// frames plus back-to-back, mode-switch and mid-frame reset sequences.
module tb_conv3x3_stream;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  localparam int IMG_CONST = 0, IMG_STEP = 1, IMG_IMP = 2, IMG_RAMP = 3;
  localparam int K_ZERO = 0, K_STEP = 1, K_BLUR = 2, K_IMAX = 3, K_PASS = 4;

  typedef struct {
    string name;
    int    mode;
    int    thresh;
    int    img;
    int    img_val;
    bit    stall;
    int    kind;
    int    exp_val;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [7:0] thresh;
  logic       frame_done, busy;

  conv3x3_stream_if #(.PIXEL_WIDTH(8)) io ();

  conv3x3_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mode       (mode),
    .i_thresh     (thresh),
    .fifo         (io),
    .o_frame_done (frame_done),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_in[$];
  logic [7:0] q_out[$];
  int done_pos[$];
  int consumed, viol, done_bad, cyc;
  int first_pop_cyc, first_wr_cyc, done_cyc;
  bit stall_en;
  vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int img, input int val, input int r, input int c);
    case (img)
      IMG_CONST: return 8'(val);
      IMG_STEP:  return (c >= 4) ? 8'(val) : 8'd0;
      IMG_IMP:   return (r == 2 && c == 2) ? 8'(val) : 8'd0;
      default:   return 8'(r * 16 + c);
    endcase
  endfunction

  // Hand-derived golden outputs for the images used here
  function automatic int exp_pix(input vec_t v, input int r, input int c);
    int dr, dc;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    dr = (r > 2) ? r - 2 : 2 - r;
    dc = (c > 2) ? c - 2 : 2 - c;
    case (v.kind)
      K_STEP: return (c == 3 || c == 4) ? v.exp_val : 0;
      K_BLUR: begin
        if (dr == 0 && dc == 0) return 40;
        if (dr + dc == 1) return 20;
        if (dr == 1 && dc == 1) return 10;
        return 0;
      end
      K_IMAX: return 255;
      K_PASS: return int'(pix(v.img, v.img_val, r, c));
      default: return 0;
    endcase
  endfunction

  // Drive FIFO models on the falling edge, then record what the next rising edge will do
  task automatic cycle();
    @(negedge clk);
    cyc++;
    io.out_full = stall_en && ($urandom_range(1, 0) == 1);
    io.in_empty = (q_in.size() == 0) || (stall_en && ($urandom_range(1, 0) == 1));
    io.in_dout  = (q_in.size() != 0) ? q_in[0] : 8'd0;
    #1;
    if (io.in_rd_en && io.in_empty) viol++;
    if (io.out_wr_en && io.out_full) viol++;
    if (io.in_rd_en) begin
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      void'(q_in.pop_front());
      consumed++;
    end
    if (io.out_wr_en) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      q_out.push_back(io.out_din);
      if (frame_done) begin
        done_pos.push_back(q_out.size());
        done_cyc = cyc;
      end
    end else if (frame_done) begin
      done_bad++;
    end
  endtask

  task automatic clear_run();
    q_out.delete();
    done_pos.delete();
    consumed = 0; viol = 0; done_bad = 0;
    first_pop_cyc = -1; first_wr_cyc = -1; done_cyc = -1;
  endtask

  task automatic push_frame(input vec_t v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        q_in.push_back(pix(v.img, v.img_val, r, c));
  endtask

  task automatic run_until(input string name, input int n);
    int budget = 4000;
    while (q_out.size() < n && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) chk({name, "_timeout"}, q_out.size(), n);
    stall_en = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic compare_frame(input vec_t v, input int base);
    for (int i = 0; i < N; i++) begin
      if (base + i < q_out.size())
        chk($sformatf("%s[%0d,%0d]", v.name, i / W, i % W), int'(q_out[base + i]),
            exp_pix(v, i / W, i % W));
    end
  endtask

  task automatic run_vec(input vec_t v, input bit timing);
    clear_run();
    mode = 2'(v.mode);
    thresh = 8'(v.thresh);
    stall_en = v.stall;
    push_frame(v);
    run_until(v.name, N);
    chk({v.name, "_count"}, q_out.size(), N);
    compare_frame(v, 0);
    chk({v.name, "_done_pulses"}, done_pos.size(), 1);
    if (done_pos.size() == 1) chk({v.name, "_done_pos"}, done_pos[0], N);
    chk({v.name, "_done_stray"}, done_bad, 0);
    chk({v.name, "_protocol"}, viol, 0);
    chk({v.name, "_busy_end"}, int'(busy), 0);
    if (timing) begin
      chk({v.name, "_latency"}, first_wr_cyc - first_pop_cyc, W + 2);
      chk({v.name, "_frame_cycles"}, done_cyc - first_pop_cyc, N + W + 1);
    end
  endtask

  initial begin
    tbl[0]  = '{name:"sobel_const",  mode:1, thresh:0,   img:IMG_CONST, img_val:100, stall:0, kind:K_ZERO, exp_val:0};
    tbl[1]  = '{name:"sobel_step",   mode:1, thresh:0,   img:IMG_STEP,  img_val:255, stall:0, kind:K_STEP, exp_val:255};
    tbl[2]  = '{name:"sobel_step10", mode:1, thresh:0,   img:IMG_STEP,  img_val:10,  stall:0, kind:K_STEP, exp_val:40};
    tbl[3]  = '{name:"gauss_imp",    mode:2, thresh:0,   img:IMG_IMP,   img_val:160, stall:0, kind:K_BLUR, exp_val:0};
    tbl[4]  = '{name:"thr_step200",  mode:3, thresh:200, img:IMG_STEP,  img_val:255, stall:0, kind:K_STEP, exp_val:255};
    tbl[5]  = '{name:"thr_equal",    mode:3, thresh:40,  img:IMG_STEP,  img_val:10,  stall:0, kind:K_STEP, exp_val:255};
    tbl[6]  = '{name:"thr_above",    mode:3, thresh:41,  img:IMG_STEP,  img_val:10,  stall:0, kind:K_ZERO, exp_val:0};
    tbl[7]  = '{name:"thr0_const",   mode:3, thresh:0,   img:IMG_CONST, img_val:100, stall:0, kind:K_IMAX, exp_val:0};
    tbl[8]  = '{name:"pass_ramp",    mode:0, thresh:0,   img:IMG_RAMP,  img_val:0,   stall:0, kind:K_PASS, exp_val:0};
    tbl[9]  = '{name:"sobel_stall",  mode:1, thresh:0,   img:IMG_STEP,  img_val:255, stall:1, kind:K_STEP, exp_val:255};
    tbl[10] = '{name:"gauss_stall",  mode:2, thresh:0,   img:IMG_IMP,   img_val:160, stall:1, kind:K_BLUR, exp_val:0};

    rst_n = 1'b0; mode = 2'd0; thresh = 8'd0; stall_en = 1'b0; cyc = 0;
    io.in_empty = 1'b0; io.in_dout = 8'd77; io.out_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_rd_en", int'(io.in_rd_en), 0);
    chk("rst_out_wr_en", int'(io.out_wr_en), 0);
    chk("rst_out_din", int'(io.out_din), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    io.in_empty = 1'b1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i == 0);

    // Back-to-back frames, mode changed to Gaussian partway through frame 1
    clear_run();
    mode = 2'd1; thresh = 8'd0; stall_en = 1'b0;
    push_frame(tbl[1]);
    push_frame(tbl[3]);
    begin
      int budget = 4000;
      bit busy_seen = 1'b0;
      while (q_out.size() < 2 * N && budget > 0) begin
        cycle();
        budget--;
        if (consumed >= 20 && mode != 2'd2) begin
          mode = 2'd2;
          chk("b2b_busy_mid", int'(busy), 1);
          busy_seen = 1'b1;
        end
      end
      if (budget == 0) chk("b2b_timeout", q_out.size(), 2 * N);
      chk("b2b_busy_checked", int'(busy_seen), 1);
      repeat (3) cycle();
    end
    chk("b2b_count", q_out.size(), 2 * N);
    compare_frame(tbl[1], 0);
    compare_frame(tbl[3], N);
    chk("b2b_done_pulses", done_pos.size(), 2);
    if (done_pos.size() == 2) begin
      chk("b2b_done_pos0", done_pos[0], N);
      chk("b2b_done_pos1", done_pos[1], 2 * N);
    end

    // Reset mid-frame after 20 pixels, then a clean frame must match golden
    clear_run();
    mode = 2'd1;
    push_frame(tbl[1]);
    begin
      int budget = 500;
      while (consumed < 20 && budget > 0) begin
        cycle();
        budget--;
      end
      if (budget == 0) chk("mid_rst_timeout", consumed, 20);
    end
    @(negedge clk);
    rst_n = 1'b0;
    io.in_empty = 1'b0; io.in_dout = 8'd200; io.out_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("mid_rst_rd_en%0d", k), int'(io.in_rd_en), 0);
      chk($sformatf("mid_rst_wr_en%0d", k), int'(io.out_wr_en), 0);
      chk($sformatf("mid_rst_din%0d", k), int'(io.out_din), 0);
      chk($sformatf("mid_rst_done%0d", k), int'(frame_done), 0);
      chk($sformatf("mid_rst_busy%0d", k), int'(busy), 0);
      @(negedge clk);
    end
    io.in_empty = 1'b1;
    rst_n = 1'b1;
    q_in.delete();
    clear_run();
    push_frame(tbl[1]);
    run_until("post_rst", N);
    chk("post_rst_count", q_out.size(), N);
    compare_frame(tbl[1], 0);
    chk("post_rst_done_pulses", done_pos.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised streaming 3×3 neighbourhood filter for the image pipeline. It replaces the fixed Sobel stage between the grayscale FIFO and the output FIFO, and sits on the same FIFO-style handshakes on both sides. The block generalises image size and pixel width, and adds four run-time modes: passthrough, Sobel magnitude, Gaussian blur and thresholded Sobel. It emits exactly one output pixel per input pixel per frame, including the flush of the trailing row.

## Interface
- IMG_WIDTH, 720, pixels per row (≥3)
- IMG_HEIGHT, 540, rows per frame (≥3)
- PIXEL_WIDTH, 8, bits per pixel, in and out
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- mode  in  2  filter select: 0 passthrough, 1 Sobel, 2 Gaussian, 3 Sobel threshold
- thresh  in  PIXEL_WIDTH  threshold for mode 3
- in_rd_en  out  1  pop upstream FIFO
- in_empty  in  1  upstream FIFO empty
- in_dout  in  PIXEL_WIDTH  upstream FIFO data (show-ahead, valid while !in_empty)
- out_wr_en  out  1  push downstream FIFO
- out_full  in  1  downstream FIFO full
- out_din  out  PIXEL_WIDTH  downstream FIFO data
- frame_done  out  1  one-cycle pulse on acceptance of a frame's last output
- busy  out  1  high from first pixel consumed until frame_done

## Operation
- Storage: two line buffers of IMG_WIDTH × PIXEL_WIDTH plus a 3×3 window register. Input column/row counters wrap at IMG_WIDTH / IMG_HEIGHT.
- Input index k = row·IMG_WIDTH + col. Consuming pixel k completes the window centred on index k−IMG_WIDTH−1.
- States:
  - FILL: consume indices 0..IMG_WIDTH, no output. Leave FILL after index IMG_WIDTH is consumed.
  - RUN: consume one pixel and produce one output, through the last index IMG_WIDTH·IMG_HEIGHT−1.
  - FLUSH: emit IMG_WIDTH+1 zeros with no input consumed. After the last zero is accepted, pulse frame_done and return to FILL.
- mode and thresh are latched when index 0 is consumed and held for the whole frame. Changes mid-frame take effect next frame.
- Border centres (row 0, row IMG_HEIGHT−1, col 0, col IMG_WIDTH−1) output 0 in every mode. FLUSH centres are all border.
- Interior arithmetic on the window w[r][c], unsigned, with MAX = 2^PIXEL_WIDTH−1:
  - Mode 0: out = centre pixel.
  - Mode 1 (Sobel): Gx = (w02+2w12+w22)−(w00+2w10+w20), Gy = (w20+2w21+w22)−(w00+2w01+w02). Both are signed, PIXEL_WIDTH+3 bits. mag = |Gx|+|Gy| in PIXEL_WIDTH+4 bits; out = min(mag, MAX).
  - Mode 2 (Gaussian): weights 1 2 1 / 2 4 2 / 1 2 1; out = (sum+8)>>4. sum is PIXEL_WIDTH+4 bits; no clamp needed.
  - Mode 3 (Sobel threshold): out = MAX if mag ≥ thresh else 0.
- Total outputs per frame = IMG_WIDTH·IMG_HEIGHT exactly. Frames run back to back with no idle cycle required.

## Timing
- Output stage is one register pair (out_valid, out_data).
  - out_wr_en = out_valid && !out_full.
  - out_din = out_data.
- in_rd_en = !in_empty && (!out_valid || !out_full) in FILL and RUN; 0 in FLUSH.
- Latency: a pixel consumed at edge t (RUN) presents its output on out_din with out_valid set from cycle t+1. Sustained throughput is 1 pixel/cycle.
- Stall: when out_full holds, out_valid and out_data are held and no pixel is consumed. No pixel is lost or duplicated.
- FLUSH loads a zero into the output register each cycle the register is free. That is one zero per cycle with no backpressure.
- in_empty during RUN: out_valid drops after the pending output is accepted; no bubble is written.
- frame_done is high in the cycle the final FLUSH write has out_wr_en=1.
- While reset is low: in_rd_en, out_wr_en, out_din, frame_done and busy are all 0. State returns to FILL and counters and window clear. Line-buffer contents are don't-care.
- Reset mid-frame: the partial frame is discarded. The next pixel after reset release is index 0 of a new frame.

## Test plan
- W=8, H=6, mode 1, constant 100 image -> 48 outputs, all 0; frame_done pulses once on the 48th write.
- W=8, H=6, mode 1, cols 0–3 = 0 and cols 4–7 = 255 -> rows 1–4, cols 3 and 4 output 255 (Gx=1020, clamped); all other outputs 0.
- W=8, H=6, mode 2, zero image with 160 at (2,2) -> (2,2)=40; (1,2), (3,2), (2,1), (2,3) = 20; diagonals = 10; rest 0. With mode 3 and thresh=200 on the step image -> same 255 positions as the Sobel step test.
- Step image, mode 1, with random in_empty and random out_full (about 50% each) -> output sequence identical to the unstalled run. in_rd_en is never high while in_empty, and out_wr_en is never high while out_full.
- Two back-to-back frames with mode switched 1→2 at pixel 20 of frame 1 -> frame 1 is fully Sobel and frame 2 is fully Gaussian; 96 outputs total.
- Reset low for 2 cycles after 20 pixels consumed -> all outputs 0 during reset. The following full frame matches the golden output exactly.
